matrix_loader: RTL

- Stream-to-RAM writer that fills the matrix memories read by the multiply datapath: A (128x128, 8-bit), B (128x1, 8-bit) and C (128x1, 16-bit).
- Accepts a byte stream over a valid/ready handshake and generates row-major write addresses and write strobes for three RAM write ports.
- Signals completion and reports a running byte checksum so the top level can launch the multiply only on a complete, verified load.

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/loader_addr_gen.sv | 44 ++++
 rtl/matrix_loader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and state type for the matrix memories and their loader.
package matrix_pkg;

   localparam int unsigned DIM     = 128;
   localparam int unsigned A_DEPTH = DIM * DIM;
   localparam int unsigned A_DW    = 8;
   localparam int unsigned B_DW    = 8;
   localparam int unsigned C_DW    = 16;
   localparam int unsigned AW      = $clog2(A_DEPTH);
   localparam int unsigned VW      = $clog2(DIM);

   typedef enum logic [2:0] {
      StIdle,
      StLoadA,
      StLoadB,
      StLoadCl,
      StLoadCh,
      StDone
   } loader_state_t;

endpackage

// File: rtl/loader_addr_gen.sv
// Index counter for the loader: row-major A index, reused as the B/C vector index.
module loader_addr_gen #(
   parameter int unsigned DIM = 128,
   parameter int unsigned AW  = 14,
   parameter int unsigned VW  = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [AW-VW-1:0] row,
   output logic [VW-1:0]    col,
   output logic             last_a,
   output logic             last_v
);

   logic [AW-1:0] idx_q, idx_d;

   // Next index: clear has priority over increment.
   always_comb begin
      idx_d = idx_q;
      if (clr) begin
         idx_d = '0;
      end else if (inc) begin
         idx_d = idx_q + 1'b1;
      end
   end

   // Index register.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   // Row-major split: upper bits select the row, lower bits the column.
   assign row    = idx_q[AW-1:VW];
   assign col    = idx_q[VW-1:0];
   assign last_a = (idx_q == AW'(DIM * DIM - 1));
   assign last_v = (idx_q == AW'(DIM - 1));

endmodule

// File: rtl/matrix_loader.sv
// Byte-stream loader filling the A, B and C matrix RAMs with a running checksum.
module matrix_loader
   import matrix_pkg::*;
#(
   parameter int unsigned DIM = matrix_pkg::DIM,
   parameter int unsigned AW  = matrix_pkg::AW,
   parameter int unsigned VW  = matrix_pkg::VW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            a_we,
   output logic [AW-1:0]   a_addr,
   output logic [A_DW-1:0] a_wdata,
   output logic            b_we,
   output logic [VW-1:0]   b_addr,
   output logic [B_DW-1:0] b_wdata,
   output logic            c_we,
   output logic [VW-1:0]   c_addr,
   output logic [C_DW-1:0] c_wdata,
   output logic            busy,
   output logic            done,
   output logic [31:0]     checksum
);

   loader_state_t state_q, state_d;

   logic             accept;
   logic             cnt_clr, cnt_inc, last_a, last_v;
   logic [AW-VW-1:0] row;
   logic [VW-1:0]    col;
   logic [7:0]       lo_q, lo_d;
   logic [31:0]      sum_q, sum_d;
   logic             done_q, done_d;
   logic             a_we_q, a_we_d, b_we_q, b_we_d, c_we_q, c_we_d;
   logic [AW-1:0]    a_addr_q, a_addr_d;
   logic [VW-1:0]    b_addr_q, b_addr_d, c_addr_q, c_addr_d;
   logic [A_DW-1:0]  a_wdata_q, a_wdata_d;
   logic [B_DW-1:0]  b_wdata_q, b_wdata_d;
   logic [C_DW-1:0]  c_wdata_q, c_wdata_d;

   loader_addr_gen #(
      .DIM (DIM),
      .AW  (AW),
      .VW  (VW)
   ) u_addr_gen (
      .clk    (clk),
      .reset  (reset),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .row    (row),
      .col    (col),
      .last_a (last_a),
      .last_v (last_v)
   );

   // Ready depends on state only, so the source may hold in_valid freely.
   assign in_ready = (state_q inside {StLoadA, StLoadB, StLoadCl, StLoadCh});
   assign busy     = in_ready;
   assign accept   = in_valid && in_ready;

   // Next-state, counter control, write-port and checksum decode.
   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      sum_d     = sum_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      a_we_d    = 1'b0;
      b_we_d    = 1'b0;
      c_we_d    = 1'b0;
      a_addr_d  = a_addr_q;
      b_addr_d  = b_addr_q;
      c_addr_d  = c_addr_q;
      a_wdata_d = a_wdata_q;
      b_wdata_d = b_wdata_q;
      c_wdata_d = c_wdata_q;
      if (accept) begin
         sum_d = sum_q + 32'(in_data);
      end
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StLoadA;
               sum_d   = '0;
               cnt_clr = 1'b1;
            end
         end
         StLoadA: begin
            if (accept) begin
               a_we_d    = 1'b1;
               a_addr_d  = {row, col};
               a_wdata_d = in_data;
               if (last_a) begin
                  state_d = StLoadB;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         StLoadB: begin
            if (accept) begin
               b_we_d    = 1'b1;
               b_addr_d  = col;
               b_wdata_d = in_data;
               if (last_v) begin
                  state_d = StLoadCl;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         StLoadCl: begin
            if (accept) begin
               lo_d    = in_data;
               state_d = StLoadCh;
            end
         end
         StLoadCh: begin
            if (accept) begin
               c_we_d    = 1'b1;
               c_addr_d  = col;
               c_wdata_d = {in_data, lo_q};
               if (last_v) begin
                  state_d = StDone;
                  cnt_clr = 1'b1;
               end else begin
                  state_d = StLoadCl;
                  cnt_inc = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // done trails entry into StDone by one cycle and drops on the restarting edge.
   assign done_d = (state_q == StDone) && !start;

   // State, write-port and checksum registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         lo_q      <= '0;
         sum_q     <= '0;
         done_q    <= 1'b0;
         a_we_q    <= 1'b0;
         b_we_q    <= 1'b0;
         c_we_q    <= 1'b0;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         c_addr_q  <= '0;
         a_wdata_q <= '0;
         b_wdata_q <= '0;
         c_wdata_q <= '0;
      end else begin
         state_q   <= state_d;
         lo_q      <= lo_d;
         sum_q     <= sum_d;
         done_q    <= done_d;
         a_we_q    <= a_we_d;
         b_we_q    <= b_we_d;
         c_we_q    <= c_we_d;
         a_addr_q  <= a_addr_d;
         b_addr_q  <= b_addr_d;
         c_addr_q  <= c_addr_d;
         a_wdata_q <= a_wdata_d;
         b_wdata_q <= b_wdata_d;
         c_wdata_q <= c_wdata_d;
      end
   end

   assign a_we     = a_we_q;
   assign a_addr   = a_addr_q;
   assign a_wdata  = a_wdata_q;
   assign b_we     = b_we_q;
   assign b_addr   = b_addr_q;
   assign b_wdata  = b_wdata_q;
   assign c_we     = c_we_q;
   assign c_addr   = c_addr_q;
   assign c_wdata  = c_wdata_q;
   assign done     = done_q;
   assign checksum = sum_q;

endmodule
